// File: rtl/adler32_pkg.sv
// Shared constants and types for the multi-lane Adler-32 engine.
// Used by both the top level and the modular reduction block.
package adler32_pkg;

    localparam int unsigned ADLER_MOD    = 65521;
    localparam int unsigned ADLER_INIT_A = 1;

    // 2^16 mod 65521; lets the upper bits be folded back into the low half.
    localparam int unsigned ADLER_FOLD   = 15;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic [15:0] b;
        logic [15:0] a;
    } checksum_t;

endpackage

// File: rtl/adler_mod_reduce.sv
// Combinational reduction of a 20-bit value modulo 65521.
// Folds bits [19:16] back in as a multiple of 15, then does one conditional subtract.
module adler_mod_reduce
    import adler32_pkg::*;
(
    input  logic [19:0] x,
    output logic [15:0] y
);

    logic [16:0] fold;

    // Max folded value is 15*15 + 65535 = 65760, below twice the modulus,
    // so a single subtract always lands the result under 65521.
    always_comb begin
        fold = 17'(x[19:16]) * 17'(ADLER_FOLD) + 17'(x[15:0]);
        if (fold >= 17'(ADLER_MOD)) begin
            y = 16'(fold - 17'(ADLER_MOD));
        end else begin
            y = fold[15:0];
        end
    end

endmodule

// File: rtl/adler32_multilane.sv
// Adler-32 checksum engine consuming LANES bytes per beat of a framed stream.
// The checksum appears with a one-cycle valid pulse the clock after the final byte.
module adler32_multilane
    import adler32_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int SIZE_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SIZE_W-1:0]    size,
    input  logic                 size_valid,
    input  logic                 data_start,
    input  logic [8*LANES-1:0]   data,
    input  logic                 data_valid,
    output logic [31:0]          checksum,
    output logic                 valid,
    output logic                 busy
);

    localparam int K_W = 3;

    state_t              state;
    logic [SIZE_W-1:0]   size_reg;
    logic [SIZE_W-1:0]   remaining;
    logic [15:0]         acc_a;
    logic [15:0]         acc_b;

    logic                start;
    logic                accept;
    logic [SIZE_W-1:0]   rem_base;
    logic [SIZE_W-1:0]   rem_next;
    logic [K_W-1:0]      k;
    logic [15:0]         a_base;
    logic [15:0]         b_base;
    logic [19:0]         sum_d;
    logic [19:0]         sum_w;
    logic [19:0]         a_pre;
    logic [19:0]         b_pre;
    logic [15:0]         a_next;
    logic [15:0]         b_next;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        start  = (state != BUSY) && data_start && data_valid;
        accept = start || ((state == BUSY) && data_valid);

        rem_base = remaining;
        a_base   = acc_a;
        b_base   = acc_b;
        if (start) begin
            rem_base = size_valid ? size : size_reg;
            a_base   = 16'(ADLER_INIT_A);
            b_base   = '0;
        end

        // Bytes taken this beat; never more than what is left, so remaining cannot wrap.
        if (rem_base >= SIZE_W'(LANES)) begin
            k = K_W'(LANES);
        end else begin
            k = K_W'(rem_base);
        end
        rem_next = rem_base - SIZE_W'(k);

        // Lane i is the (i+1)-th byte of the beat, so it is added into A k-i times by the end.
        sum_d = '0;
        sum_w = '0;
        for (int i = 0; i < LANES; i++) begin
            if (K_W'(i) < k) begin
                sum_d = sum_d + 20'(data[8*i +: 8]);
                sum_w = sum_w + 20'(k - K_W'(i)) * 20'(data[8*i +: 8]);
            end
        end

        a_pre = 20'(a_base) + sum_d;
        b_pre = 20'(b_base) + 20'(k) * 20'(a_base) + sum_w;
    end

    adler_mod_reduce u_reduce_a (
        .x (a_pre),
        .y (a_next)
    );

    adler_mod_reduce u_reduce_b (
        .x (b_pre),
        .y (b_next)
    );

    // NOTE: sequential state uses non-blocking assignments and every register, accumulators included, has an async reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            size_reg  <= '0;
            remaining <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            checksum  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;

            if ((state != BUSY) && size_valid) begin
                size_reg <= size;
            end

            if (accept) begin
                acc_a     <= a_next;
                acc_b     <= b_next;
                remaining <= rem_next;
                if (rem_next == '0) begin
                    state    <= DONE;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    checksum <= checksum_t'{b: b_next, a: a_next};
                end else begin
                    state <= BUSY;
                    busy  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adler32_multilane.sv
// Self-checking bench for adler32_multilane: table-driven frames on a 4-lane instance,
// a 1-lane instance, a long frame, back-to-back frames and a mid-frame reset.
module tb_adler32_multilane;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] size;
    logic        size_valid;
    logic        data_start;
    logic [31:0] data;
    logic        data_valid;
    logic [31:0] checksum;
    logic        valid;
    logic        busy;

    logic [31:0] size1;
    logic        size_valid1;
    logic        data_start1;
    logic [7:0]  data1;
    logic        data_valid1;
    logic [31:0] checksum1;
    logic        valid1;
    logic        busy1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          due;
    } sb_t;

    typedef struct {
        string       name;
        string       text;
        int          size;
        int          gap;
        bit          noise;
        bit          pre;
        int          idle;
        bit          use_exp;
        logic [31:0] exp;
    } vec_t;

    sb_t          sb[$];
    sb_t          mon_e;
    byte unsigned frame_q[$];
    vec_t         vecs[8];

    adler32_multilane #(.LANES(4), .SIZE_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .size       (size),
        .size_valid (size_valid),
        .data_start (data_start),
        .data       (data),
        .data_valid (data_valid),
        .checksum   (checksum),
        .valid      (valid),
        .busy       (busy)
    );

    adler32_multilane #(.LANES(1), .SIZE_W(32)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .size       (size1),
        .size_valid (size_valid1),
        .data_start (data_start1),
        .data       (data1),
        .data_valid (data_valid1),
        .checksum   (checksum1),
        .valid      (valid1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-serial reference, independent of the lane-parallel formulation.
    function automatic logic [31:0] adler_ref();
        int unsigned a = 1;
        int unsigned b = 0;
        foreach (frame_q[i]) begin
            a = (a + frame_q[i]) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    task automatic load_str(input string s);
        frame_q.delete();
        for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (!reset && valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 checksum=%h, expected no valid", checksum);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " checksum"}, checksum, mon_e.exp);
                check({mon_e.name, " latency_cycle"}, 32'(cyc), 32'(mon_e.due));
                check({mon_e.name, " busy_at_valid"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic send_frame(input string name, input int sz, input int gap, input bit noise,
                              input bit pre, input logic [31:0] exp);
        int  nbeats;
        sb_t e;
        nbeats = (sz == 0) ? 1 : (sz + 3) / 4;
        if (pre) begin
            size       = sz;
            size_valid = 1'b1;
            data_start = 1'b0;
            data_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++) begin
                int idx;
                idx = b * 4 + l;
                data[8*l +: 8] = (idx < sz) ? frame_q[idx] : 8'($urandom);
            end
            data_valid = 1'b1;
            if (b == 0) begin
                data_start = 1'b1;
                size_valid = !pre;
                size       = pre ? 32'd77 : sz;
            end else begin
                data_start = noise;
                size_valid = noise;
                size       = 32'd2;
            end
            if (b == nbeats - 1) begin
                e.name = name;
                e.exp  = exp;
                e.due  = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (b != nbeats - 1) begin
                repeat (gap) begin
                    data_valid = 1'b0;
                    data_start = noise;
                    size_valid = noise;
                    size       = 32'd2;
                    @(posedge clk); #1;
                end
            end
        end
        data_valid = 1'b0;
        data_start = 1'b0;
        size_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        sb_t e;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no valid within %0d cycles, expected checksum %h", e.name, budget, e.exp);
        end
    endtask

    task automatic run1(input string name, input string s, input logic [31:0] exp);
        for (int i = 0; i < s.len(); i++) begin
            data1       = s[i];
            size1       = s.len();
            size_valid1 = (i == 0);
            data_start1 = (i == 0);
            data_valid1 = 1'b1;
            @(posedge clk); #1;
        end
        data_valid1 = 1'b0;
        data_start1 = 1'b0;
        size_valid1 = 1'b0;
        check({name, " valid"}, 32'(valid1), 32'd1);
        check({name, " checksum"}, checksum1, exp);
        check({name, " busy"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        logic [31:0] exp;

        size = '0; size_valid = 1'b0; data_start = 1'b0; data = '0; data_valid = 1'b0;
        size1 = '0; size_valid1 = 1'b0; data_start1 = 1'b0; data1 = '0; data_valid1 = 1'b0;

        //            name        text             size gap noise pre idle use  exp
        vecs[0] = '{"abc",       "abc",            3,   0,  0,    0,  0,   1,   32'h024D0127};
        vecs[1] = '{"wikipedia", "Wikipedia",      9,   0,  0,    0,  2,   1,   32'h11E60398};
        vecs[2] = '{"a",         "a",              1,   0,  0,    0,  1,   1,   32'h00620062};
        vecs[3] = '{"size0",     "",               0,   0,  0,    0,  3,   1,   32'h00000001};
        vecs[4] = '{"wiki_gap3", "Wikipedia",      9,   3,  1,    0,  0,   1,   32'h11E60398};
        vecs[5] = '{"hello_pre", "Hello, world!",  13,  1,  1,    1,  2,   0,   32'h0};
        vecs[6] = '{"exact8",    "12345678",       8,   0,  0,    0,  0,   0,   32'h0};
        vecs[7] = '{"seven_pre", "abcdefg",        7,   2,  0,    1,  2,   0,   32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset checksum", checksum, 32'h0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run1("lane1_a", "a", 32'h00620062);
        run1("lane1_wikipedia", "Wikipedia", 32'h11E60398);

        for (int i = 0; i < 8; i++) begin
            load_str(vecs[i].text);
            exp = vecs[i].use_exp ? vecs[i].exp : adler_ref();
            send_frame(vecs[i].name, vecs[i].size, vecs[i].gap, vecs[i].noise, vecs[i].pre, exp);
            repeat (vecs[i].idle) begin
                @(posedge clk); #1;
            end
        end
        drain(20);

        // Long frame overflows both sums many times; the next frame starts in its valid cycle.
        frame_q.delete();
        repeat (70000) frame_q.push_back(8'hFF);
        exp = adler_ref();
        send_frame("ff70000", 70000, 0, 0, 0, exp);
        load_str("abc");
        send_frame("b2b_abc", 3, 0, 0, 0, 32'h024D0127);
        drain(20);

        // Mid-frame reset: first 4 bytes of an 8-byte frame, then reset.
        load_str("abcdefgh");
        for (int l = 0; l < 4; l++) data[8*l +: 8] = frame_q[l];
        size       = 32'd8;
        size_valid = 1'b1;
        data_start = 1'b1;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        data_start = 1'b0;
        size_valid = 1'b0;
        check("midframe busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midframe_reset checksum", checksum, 32'h0);
        check("midframe_reset valid", 32'(valid), 32'd0);
        check("midframe_reset busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Tail of the discarded frame arrives without data_start and must be ignored.
        for (int l = 0; l < 4; l++) data[8*l +: 8] = frame_q[4 + l];
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_reset busy", 32'(busy), 32'd0);

        load_str("abc");
        send_frame("after_reset_abc", 3, 0, 0, 0, 32'h024D0127);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
